// File: rtl/arith_pkg.sv
// Shared definitions for the small arithmetic unit: state encoding and default width.
package arith_pkg;

   localparam int unsigned AUC_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_sub_1b.sv
// One-bit full subtractor: x - y - bin, giving difference bit and borrow out.
module full_sub_1b (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Borrow out when x=0,y=1, or when x==y and a borrow is already pending.
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, with borrow/zero/overflow flags.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned W = AUC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow,
   output logic         zero,
   output logic         ovf
);

   localparam int unsigned CNT_W = $clog2(W) + 1;

   sub_state_t       state;
   sub_state_t       state_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   logic [W-1:0]     a_sh;
   logic [W-1:0]     b_sh;
   logic [W-2:0]     diff_sh;
   logic [CNT_W-1:0] cnt;
   logic             br;
   logic             a_msb;
   logic             b_msb;

   logic             d_bit;
   logic             br_nxt;
   logic [W-1:0]     diff_cat;
   logic             last_bit;
   logic             accept;

   // Single bit-slice shared by every cycle of the operation.
   full_sub_1b u_fs (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_nxt)
   );

   // New bit enters at the top; after the final bit this is the full difference.
   assign diff_cat = {d_bit, diff_sh};
   assign last_bit = (state == RUN) && (cnt == CNT_W'(W - 1));
   assign accept   = start && (state != RUN);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; start is only honoured outside RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the upcoming state so they register cleanly.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         RUN:     busy_nxt = 1'b1;
         DONE:    done_nxt = 1'b1;
         default: ;
      endcase
   end

   // Handshake output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Operand capture and per-bit shifting of operands, borrow, partial difference.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
      end else if (accept) begin
         a_sh    <= a;
         b_sh    <= b;
         diff_sh <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         a_msb   <= a[W-1];
         b_msb   <= b[W-1];
      end else if (state == RUN) begin
         a_sh    <= {1'b0, a_sh[W-1:1]};
         b_sh    <= {1'b0, b_sh[W-1:1]};
         diff_sh <= diff_cat[W-1:1];
         cnt     <= cnt + CNT_W'(1);
         br      <= br_nxt;
      end
   end

   // Result registers load only with the final bit, so partial sums never show.
   always_ff @(posedge clk) begin
      if (rst) begin
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else if (last_bit) begin
         diff   <= diff_cat;
         borrow <= br_nxt;
         zero   <= (diff_cat == '0);
         ovf    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases, exhaustive 4-bit sweep, random ops.
module tb_serial_subtractor;
   import arith_pkg::*;

   localparam int unsigned W = AUC_W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         zero;
   logic         ovf;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         zero;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   serial_subtractor #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input int av, input int bv);
      exp_t e;
      int   sa;
      int   sb;
      int   sr;
      int   full;
      full     = 2 ** W;
      e.diff   = W'(((av - bv) % full + full) % full);
      e.borrow = (av < bv);
      e.zero   = (((av - bv) % full + full) % full) == 0;
      sa       = (av >= full / 2) ? av - full : av;
      sb       = (bv >= full / 2) ? bv - full : bv;
      sr       = sa - sb;
      e.ovf    = (sr < -(full / 2)) || (sr > full / 2 - 1);
      return e;
   endfunction

   // Monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1 diff=%0d, required no pending result", diff);
         end else begin
            mon_e = sb_q.pop_front();
            if (diff !== mon_e.diff || borrow !== mon_e.borrow ||
                zero !== mon_e.zero || ovf !== mon_e.ovf) begin
               errors++;
               $display("FAIL result: got diff=%0d borrow=%0b zero=%0b ovf=%0b, required diff=%0d borrow=%0b zero=%0b ovf=%0b",
                        diff, borrow, zero, ovf, mon_e.diff, mon_e.borrow, mon_e.zero, mon_e.ovf);
            end
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got busy=%0b, required 0", busy);
         end
      end
   end

   // Present operands with start; caller is positioned at a negedge.
   task automatic drive(input int av, input int bv, input bit push);
      a     = W'(av);
      b     = W'(bv);
      start = 1'b1;
      if (push) sb_q.push_back(model(av, bv));
   endtask

   // Wait for done and check latency; optionally pokes start mid-run.
   task automatic wait_done(input string name, input bit poke);
      int k;
      bit seen;
      k    = 1;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (poke && k == 2) begin
            a     = W'(0);
            b     = W'(1);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen || k != int'(W) + 1) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles (done seen=%0b), required %0d", name, k, seen, W + 1);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0 ||
          zero !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got busy=%0b done=%0b diff=%0d borrow=%0b zero=%0b ovf=%0b, required all 0",
                  busy, done, diff, borrow, zero, ovf);
      end
      rst = 1'b0;

      // Directed cases.
      @(negedge clk);
      drive(9, 4, 1'b1);  wait_done("a9_b4", 1'b0);
      @(negedge clk);
      drive(4, 9, 1'b1);  wait_done("a4_b9", 1'b0);
      @(negedge clk);
      drive(7, 7, 1'b1);  wait_done("a7_b7", 1'b0);
      @(negedge clk);
      drive(8, 1, 1'b1);  wait_done("a8_b1_ignored_start", 1'b1);
      repeat (8) @(negedge clk);

      // Reset in the middle of RUN: no done, outputs cleared.
      drive(15, 3, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0 ||
          zero !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_reset: got busy=%0b done=%0b diff=%0d borrow=%0b zero=%0b ovf=%0b, required all 0",
                  busy, done, diff, borrow, zero, ovf);
      end
      rst = 1'b0;
      repeat (8) @(negedge clk);
      drive(3, 15, 1'b1); wait_done("a3_b15_after_reset", 1'b0);

      // Exhaustive sweep with back-to-back starts issued in the DONE cycle.
      @(negedge clk);
      for (int i = 0; i < 2 ** W; i++) begin
         for (int j = 0; j < 2 ** W; j++) begin
            drive(i, j, 1'b1);
            wait_done("exhaustive", 1'b0);
         end
      end

      // Random operations with random idle gaps.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(3, 1)) @(negedge clk);
         drive(int'($urandom_range(2 ** W - 1, 0)), int'($urandom_range(2 ** W - 1, 0)), 1'b1);
         wait_done("random", 1'b0);
      end

      repeat (8) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
